// File: rtl/rp_8bit_uart_pkg.sv
// rp_8bit_uart_pkg: register offsets, STA/CTL/IRQ bit indices and FSM state types for rp_8bit_uart.
package rp_8bit_uart_pkg;
    localparam logic [5:0] OFS_UDR = 6'd0;
    localparam logic [5:0] OFS_STA = 6'd1;
    localparam logic [5:0] OFS_CTL = 6'd2;
    localparam logic [5:0] OFS_BRR = 6'd3;
    localparam int STA_RXC   = 7;
    localparam int STA_TXC   = 6;
    localparam int STA_DRE   = 5;
    localparam int STA_FE    = 4;
    localparam int STA_DOR   = 3;
    localparam int CTL_RXCIE = 7;
    localparam int CTL_TXCIE = 6;
    localparam int CTL_UDRIE = 5;
    localparam int CTL_RXEN  = 4;
    localparam int CTL_TXEN  = 3;
    localparam int CTL_LPB   = 0;
    localparam int IRQ_RXC   = 0;
    localparam int IRQ_DRE   = 1;
    localparam int IRQ_TXC   = 2;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/rp_8bit_uart_rx.sv
// rp_8bit_uart_rx: 2-FF synchronizer and 8N1 receive FSM; samples each bit (BRR+1)>>1 clocks into it.
module rp_8bit_uart_rx
    import rp_8bit_uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_rxd,
    input  logic [7:0] i_brr,
    output logic [7:0] o_data,
    output logic       o_done,
    output logic       o_stop
);
    rx_state_t  r_state, w_next;
    logic [1:0] r_sync;
    logic [7:0] r_cnt, r_sh, w_half;
    logic [2:0] r_bit;
    logic       w_rx, w_fall, w_tick;

    assign w_rx   = r_sync[1];
    // Edge is taken as the synchronizer output about to fall, so the start bit is timed from its first low cycle.
    assign w_fall = r_sync[1] & ~r_sync[0];
    assign w_tick = (r_cnt == 8'd0);
    assign w_half = 8'((9'(i_brr) + 9'd1) >> 1);
    assign o_data = r_sh;
    assign o_stop = w_rx;
    assign o_done = i_en & (r_state == RX_STOP) & w_tick;

    always_comb begin
        w_next = r_state;
        if (!i_en)
            w_next = RX_IDLE;
        else
            case (r_state)
                RX_IDLE:  if (w_fall) w_next = RX_START;
                RX_START: if (w_tick) w_next = w_rx ? RX_IDLE : RX_DATA;
                RX_DATA:  if (w_tick && r_bit == 3'd7) w_next = RX_STOP;
                RX_STOP:  if (w_tick) w_next = RX_IDLE;
                default:  w_next = RX_IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RX_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_cnt  <= 8'd0;
            r_sh   <= 8'd0;
            r_bit  <= 3'd0;
        end else begin
            r_sync <= {r_sync[0], i_rxd};
            if (r_state == RX_IDLE) begin
                r_cnt <= w_half;
                r_bit <= 3'd0;
            end else if (w_tick) begin
                r_cnt <= i_brr;
                if (r_state == RX_DATA) begin
                    r_sh  <= {w_rx, r_sh[7:1]};
                    r_bit <= r_bit + 3'd1;
                end
            end else
                r_cnt <= r_cnt - 8'd1;
        end
    end
endmodule

// File: rtl/rp_8bit_uart.sv
// rp_8bit_uart: 8N1 UART on the rp_8bit I/O bus with UDR/STA/CTL/BRR at BAS..BAS+3 and three IRQ lines.
// Define RP_8BIT_UART_LOOPBACK_EN to add CTL.LPB (TX shifter looped into RX, uart_txd held high).
module rp_8bit_uart
    import rp_8bit_uart_pkg::*;
#(
    parameter logic [5:0] BAS     = 6'h20,
    parameter logic [7:0] BRR_RST = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_wen,
    input  logic       io_ren,
    input  logic [5:0] io_adr,
    input  logic [7:0] io_wdt,
    input  logic [7:0] io_msk,
    output logic [7:0] io_rdt,
    output logic [2:0] irq_req,
    input  logic [2:0] irq_ack,
    output logic       uart_txd,
    input  logic       uart_rxd
);
    tx_state_t  r_tx_state, w_tx_next;
    logic [7:0] r_ctl, r_brr, r_tx_buf, r_tx_sh, r_tx_cnt, r_rx_buf, r_rdt;
    logic [7:0] w_sta, w_rd_mux, w_rx_data, w_ctl_m;
    logic [5:0] w_ofs;
    logic [2:0] r_tx_bit;
    logic       r_tx_full, r_txd, r_rxc, r_txc, r_fe, r_dor;
    logic       w_udr_wr, w_udr_rd, w_txc_clr, w_tx_tick, w_tx_end, w_tx_load;
    logic       w_lpb, w_rx_in, w_rx_done, w_rx_stop;

`ifdef RP_8BIT_UART_LOOPBACK_EN
    localparam logic [7:0] CTL_WMSK = 8'hF9;
    assign w_lpb   = r_ctl[CTL_LPB];
    assign w_rx_in = w_lpb ? r_txd : uart_rxd;
`else
    localparam logic [7:0] CTL_WMSK = 8'hF8;
    assign w_lpb   = 1'b0;
    assign w_rx_in = uart_rxd;
`endif

    assign uart_txd  = r_txd | w_lpb;
    assign io_rdt    = r_rdt;
    assign w_ofs     = io_adr - BAS;
    assign w_ctl_m   = io_msk & CTL_WMSK;
    assign w_udr_wr  = io_wen & (w_ofs == OFS_UDR) & (|io_msk);
    assign w_udr_rd  = io_ren & (w_ofs == OFS_UDR);
    assign w_txc_clr = irq_ack[IRQ_TXC] | (io_wen & (w_ofs == OFS_STA) & io_msk[STA_TXC] & io_wdt[STA_TXC]);
    assign w_rd_mux  = (w_ofs == OFS_UDR) ? r_rx_buf :
                       (w_ofs == OFS_STA) ? w_sta :
                       (w_ofs == OFS_CTL) ? r_ctl :
                       (w_ofs == OFS_BRR) ? r_brr : 8'h00;

    always_comb begin
        w_sta          = 8'h00;
        w_sta[STA_RXC] = r_rxc;
        w_sta[STA_TXC] = r_txc;
        w_sta[STA_DRE] = ~r_tx_full;
        w_sta[STA_FE]  = r_fe;
        w_sta[STA_DOR] = r_dor;
    end

    always_comb begin
        irq_req          = 3'b000;
        irq_req[IRQ_RXC] = r_rxc & r_ctl[CTL_RXCIE];
        irq_req[IRQ_DRE] = ~r_tx_full & r_ctl[CTL_UDRIE];
        irq_req[IRQ_TXC] = r_txc & r_ctl[CTL_TXCIE];
    end

    assign w_tx_tick = (r_tx_cnt == 8'd0);
    assign w_tx_end  = (r_tx_state == TX_STOP) & w_tx_tick;
    // A full buffer moves to the shifter from idle or straight out of a stop bit, so frames run back to back.
    assign w_tx_load = r_tx_full & r_ctl[CTL_TXEN] & ((r_tx_state == TX_IDLE) | w_tx_end);

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_tx_load) w_tx_next = TX_START;
            TX_START: if (w_tx_tick) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_tick) w_tx_next = w_tx_load ? TX_START : TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sh  <= 8'd0;
            r_tx_cnt <= 8'd0;
            r_tx_bit <= 3'd0;
            r_txd    <= 1'b1;
        end else if (w_tx_load) begin
            r_tx_sh  <= r_tx_buf;
            r_tx_cnt <= r_brr;
            r_tx_bit <= 3'd0;
            r_txd    <= 1'b0;
        end else if (r_tx_state != TX_IDLE) begin
            if (w_tx_tick) begin
                r_tx_cnt <= r_brr;
                if (r_tx_state == TX_START)
                    r_txd <= r_tx_sh[0];
                else if (r_tx_state == TX_DATA) begin
                    r_tx_sh  <= r_tx_sh >> 1;
                    r_tx_bit <= r_tx_bit + 3'd1;
                    r_txd    <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_sh[1];
                end else
                    r_txd <= 1'b1;
            end else
                r_tx_cnt <= r_tx_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctl     <= 8'h00;
            r_brr     <= BRR_RST;
            r_tx_buf  <= 8'h00;
            r_tx_full <= 1'b0;
            r_rx_buf  <= 8'h00;
            r_rxc     <= 1'b0;
            r_txc     <= 1'b0;
            r_fe      <= 1'b0;
            r_dor     <= 1'b0;
            r_rdt     <= 8'h00;
        end else begin
            if (io_wen && w_ofs == OFS_CTL) r_ctl <= (r_ctl & ~w_ctl_m) | (io_wdt & w_ctl_m);
            if (io_wen && w_ofs == OFS_BRR) r_brr <= (r_brr & ~io_msk) | (io_wdt & io_msk);
            if (w_udr_wr && !r_tx_full) begin
                r_tx_buf  <= (r_tx_buf & ~io_msk) | (io_wdt & io_msk);
                r_tx_full <= 1'b1;
            end else if (w_tx_load)
                r_tx_full <= 1'b0;
            if (io_ren) r_rdt <= w_rd_mux;
            if (w_udr_rd) begin
                r_rxc <= 1'b0;
                r_fe  <= 1'b0;
                r_dor <= 1'b0;
            end
            // A read in the completion cycle has already taken the old byte, so the new one is kept, not overrun.
            if (w_rx_done) begin
                if (!r_rxc || w_udr_rd) begin
                    r_rx_buf <= w_rx_data;
                    r_rxc    <= 1'b1;
                    r_fe     <= ~w_rx_stop;
                end else
                    r_dor <= 1'b1;
            end
            if (w_txc_clr) r_txc <= 1'b0;
            if (w_tx_end && !w_tx_load) r_txc <= 1'b1;
        end
    end

    rp_8bit_uart_rx u_rx (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_ctl[CTL_RXEN]),
        .i_rxd  (w_rx_in),
        .i_brr  (r_brr),
        .o_data (w_rx_data),
        .o_done (w_rx_done),
        .o_stop (w_rx_stop)
    );
endmodule

// File: tb/tb_rp_8bit_uart.sv
// tb_rp_8bit_uart: directed and randomized checks of rp_8bit_uart against a register-level behavioural model.
module tb_rp_8bit_uart;
    localparam logic [5:0] BAS = 6'h20;

    logic       clk = 1'b0, rst = 1'b1, io_wen = 1'b0, io_ren = 1'b0, uart_rxd = 1'b1;
    logic [5:0] io_adr = 6'd0;
    logic [7:0] io_wdt = 8'd0, io_msk = 8'd0;
    logic [7:0] io_rdt;
    logic [2:0] irq_req, irq_ack = 3'b000;
    logic       uart_txd;
    int         n_cmp = 0, n_err = 0;

    logic       m_rxc = 0, m_txc = 0, m_fe = 0, m_dor = 0, m_dre = 1;
    logic [7:0] m_rx = 0, m_ctl = 0, m_brr = 0;

    rp_8bit_uart dut (
        .clk(clk), .rst(rst), .io_wen(io_wen), .io_ren(io_ren), .io_adr(io_adr),
        .io_wdt(io_wdt), .io_msk(io_msk), .io_rdt(io_rdt), .irq_req(irq_req),
        .irq_ack(irq_ack), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic [7:0] m);
        @(negedge clk);
        io_wen = 1'b1; io_adr = a; io_wdt = d; io_msk = m;
        @(negedge clk);
        io_wen = 1'b0; io_msk = 8'h00;
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        @(negedge clk);
        io_ren = 1'b1; io_adr = a;
        @(negedge clk);
        io_ren = 1'b0;
        d = io_rdt;
    endtask

    task automatic set_brr(input logic [7:0] b);
        wr(BAS + 6'd3, b, 8'hFF);
        m_brr = b;
    endtask

    task automatic set_ctl(input logic [7:0] c);
        wr(BAS + 6'd2, c, 8'hFF);
        m_ctl = c & 8'hF8;
    endtask

    task automatic check_sta(input string tag);
        logic [7:0] d;
        rd(BAS + 6'd1, d);
        chk({tag, "_sta"}, d, {m_rxc, m_txc, m_dre, m_fe, m_dor, 3'b000});
        chk({tag, "_irq"}, irq_req, {m_txc & m_ctl[6], m_dre & m_ctl[5], m_rxc & m_ctl[7]});
    endtask

    task automatic rd_udr(input string tag);
        logic [7:0] d;
        rd(BAS, d);
        chk({tag, "_udr"}, d, m_rx);
        m_rxc = 0; m_fe = 0; m_dor = 0;
    endtask

    // Samples uart_txd every clock from the edge after the UDR write and compares against the ideal waveform.
    task automatic tx_capture(input logic [19:0] bits, input int nb, input string tag);
        int t, bad;
        logic [19:0] got;
        t = int'(m_brr) + 1; bad = 0; got = 20'd0;
        for (int i = 0; i < nb * t; i++) begin
            @(posedge clk); #1;
            if (uart_txd !== bits[i / t]) bad++;
            if (i % t == t / 2) got[i / t] = uart_txd;
        end
        chk({tag, "_bits"}, got, bits);
        chk({tag, "_shape"}, bad, 0);
        @(negedge clk); @(negedge clk);
        m_txc = 1;
    endtask

    task automatic tx_send(input logic [7:0] b, input string tag);
        wr(BAS, b, 8'hFF);
        tx_capture({10'd0, 1'b1, b, 1'b0}, 10, tag);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        int t;
        logic [9:0] bits;
        t = int'(m_brr) + 1;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = bits[i];
            repeat (t) @(negedge clk);
        end
        uart_rxd = 1'b1;
        repeat (t + 4) @(negedge clk);
        if (m_ctl[4]) begin
            if (!m_rxc) begin m_rxc = 1; m_rx = b; m_fe = ~stop; end
            else m_dor = 1;
        end
    endtask

    task automatic b2b_test();
        logic [7:0] s;
        int k;
        wr(BAS, 8'h55, 8'hFF);
        fork
            tx_capture({1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0}, 20, "b2b");
            begin
                k = 0;
                do begin rd(BAS + 6'd1, s); k++; end while (!s[5] && k < 50);
                chk("b2b_dre_wait", s[5], 1'b1);
                wr(BAS, 8'h0F, 8'hFF);
                rd(BAS + 6'd1, s);
                chk("b2b_dre_full", s[5], 1'b0);
                chk("b2b_txc_mid", s[6], 1'b0);
            end
        join
    endtask

    initial begin
        logic [7:0] d, c;
        int lows;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_rdt", io_rdt, 8'h00);
        chk("rst_txd", uart_txd, 1'b1);
        chk("rst_irq", irq_req, 3'b000);
        check_sta("rst");
        rd(BAS + 6'd2, d); chk("rst_ctl", d, 8'h00);
        rd(BAS + 6'd3, d); chk("rst_brr", d, 8'h00);

        set_brr(8'd3);
        set_ctl(8'h48);
        wr(BAS, 8'hAA, 8'h00);
        lows = 0;
        repeat (12) begin @(posedge clk); #1; if (uart_txd !== 1'b1) lows++; end
        chk("udr_msk0_idle", lows, 0);
        check_sta("udr_msk0");
        tx_send(8'hA5, "txa5");
        check_sta("txa5_done");
        @(negedge clk); irq_ack = 3'b100; @(negedge clk); irq_ack = 3'b000;
        m_txc = 0;
        check_sta("txa5_ack");

        b2b_test();
        check_sta("b2b_done");
        wr(BAS + 6'd1, 8'hBF, 8'hFF);
        check_sta("sta_ro");
        wr(BAS + 6'd1, 8'h40, 8'h40); m_txc = 0;
        check_sta("sta_w1c");

        set_ctl(8'h00);
        wr(BAS, 8'h81, 8'hFF);
        m_dre = 0;
        check_sta("dre_full");
        wr(BAS, 8'h7E, 8'hFF);
        wr(BAS + 6'd2, 8'h08, 8'hFF); m_ctl = 8'h08; m_dre = 1;
        tx_capture({10'd0, 1'b1, 8'h81, 1'b0}, 10, "drop");

        set_ctl(8'h98);
        rx_send(8'h3C, 1'b1);
        check_sta("rx3c");
        rd_udr("rx3c");
        check_sta("rx3c_clr");
        rx_send(8'h11, 1'b1);
        rx_send(8'h22, 1'b1);
        check_sta("dor");
        rd_udr("dor");
        check_sta("dor_clr");
        rx_send(8'h5A, 1'b0);
        check_sta("fe");
        rd_udr("fe");
        uart_rxd = 1'b0; repeat (2) @(negedge clk); uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        check_sta("glitch");

        set_ctl(8'h00);
        wr(BAS + 6'd2, 8'hFF, 8'h10); m_ctl = 8'h10;
        rd(BAS + 6'd2, d); chk("ctl_msk", d, m_ctl);
        wr(BAS + 6'd3, 8'hFF, 8'h0C); m_brr = 8'h0F;
        rd(BAS + 6'd3, d); chk("brr_msk", d, m_brr);
        wr(BAS + 6'd4, 8'hFF, 8'hFF);
        rd(BAS + 6'd2, d); chk("oor_wr", d, m_ctl);
        wr(BAS + 6'd2, 8'h00, 8'hFF);
        repeat (3) @(negedge clk);
        chk("rdt_hold", io_rdt, 8'h10);
        m_ctl = 8'h00;
        rd(BAS + 6'd4, d); chk("oor_rd_hi", d, 8'h00);
        rd(BAS - 6'd1, d); chk("oor_rd_lo", d, 8'h00);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) set_brr(8'($urandom_range(1, 6)));
            case ($urandom_range(0, 4))
                0: begin
                    if (!m_ctl[4] || !m_ctl[3]) set_ctl(m_ctl | 8'h18);
                    rx_send(8'($urandom), $urandom_range(0, 5) != 0);
                end
                1: rd_udr("rnd");
                2: begin
                    if (!m_ctl[3]) set_ctl(m_ctl | 8'h18);
                    tx_send(8'($urandom), "rnd_tx");
                end
                3: begin
                    c = (8'($urandom) & 8'hE0) | 8'h18;
                    set_ctl(c);
                end
                default: begin
                    @(negedge clk); irq_ack = 3'($urandom); c = {5'd0, irq_ack};
                    @(negedge clk); irq_ack = 3'b000;
                    if (c[2]) m_txc = 0;
                end
            endcase
            check_sta("rnd");
        end

        set_brr(8'd3);
        set_ctl(8'h08);
        wr(BAS, 8'h00, 8'hFF);
        @(negedge clk);
        chk("mid_rst_pre", uart_txd, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_txd", uart_txd, 1'b1);
        rst = 1'b0;
        m_rxc = 0; m_txc = 0; m_fe = 0; m_dor = 0; m_dre = 1; m_ctl = 0; m_brr = 0;
        lows = 0;
        repeat (20) begin @(posedge clk); #1; if (uart_txd !== 1'b1) lows++; end
        chk("mid_rst_idle", lows, 0);
        check_sta("mid_rst");
        rd(BAS + 6'd3, d); chk("mid_rst_brr", d, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
